// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional checksum stage is enabled by INSTR_LOADER_CHECKSUM_EN.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream valid/ready channel from the host bridge into the loader.
interface instr_mem_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/instr_mem_loader_byte_word_asm.sv
// Assembles four accepted bytes into one little-endian 32-bit word.
module byte_word_asm
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    localparam int CNT_W   = $clog2(WORD_BYTES);
    localparam int SHIFT_W = 8 * (WORD_BYTES - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [SHIFT_W-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Earlier bytes drift toward the LSBs; the last byte is merged combinationally.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_shift <= {i_byte, r_shift[SHIFT_W-1:8]};
        end
    end

    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_en && (r_cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed word image into instruction memory and holds the core
// in reset until done. Define INSTR_LOADER_CHECKSUM_EN for the trailing XOR checksum.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    instr_mem_loader_if.slave s_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);
    localparam int          HDR_W    = 8 * HDR_BYTES;
    localparam logic [31:0] CAPACITY = 32'((1 << ADDR_W) - START_ADDR);

    loader_state_e     r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_rst;
    logic              r_done;
    logic              r_err;
    logic [7:0]        r_n_lo;
    logic [HDR_W-1:0]  r_remain;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_in_ready;
    logic              w_xfer;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [HDR_W-1:0]  w_hdr_n;

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            HDR_LO, HDR_HI, DATA: w_in_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CSUM:                 w_in_ready = 1'b1;
`endif
            default:              w_in_ready = 1'b0;
        endcase
    end

    assign w_xfer  = s_in.in_valid && w_in_ready;
    assign w_hdr_n = {s_in.in_data, r_n_lo};

    byte_word_asm u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_xfer && (r_state == DATA)),
        .i_byte       (s_in.in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HDR_LO;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_W'(START_ADDR);
            r_mem_wdata <= '0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_n_lo      <= '0;
            r_remain    <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                HDR_LO: if (w_xfer) begin
                    r_n_lo  <= s_in.in_data;
                    r_state <= HDR_HI;
                end
                HDR_HI: if (w_xfer) begin
                    r_remain <= w_hdr_n;
                    if (w_hdr_n == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_state    <= CSUM;
`else
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
`endif
                    end else if (32'(w_hdr_n) > CAPACITY) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= DATA;
                    end
                end
                DATA: if (w_xfer) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ s_in.in_data;
`endif
                    if (w_word_valid) begin
                        r_state     <= WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_word;
                    end
                end
                // Single write cycle: advance address, retire one word.
                WRITE: begin
                    r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    r_remain   <= r_remain - HDR_W'(1);
                    if (r_remain == HDR_W'(1)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        r_state    <= CSUM;
`else
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
`endif
                    end else begin
                        r_state <= DATA;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CSUM: if (w_xfer) begin
                    if (s_in.in_data == r_csum) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
                    end else begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end
                end
`endif
                DONE, ERR: r_state <= r_state;
                default:   r_state <= HDR_LO;
            endcase
        end
    end

    assign s_in.in_ready = w_in_ready;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign core_rst      = r_core_rst;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: scenario tasks against a queue-based image model.
// Honours INSTR_LOADER_CHECKSUM_EN to match the DUT build.
module tb_instr_mem_loader;

    localparam int ADDR_W     = 8;
    localparam int START_ADDR = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_loader_if bus ();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    instr_mem_loader #(.ADDR_W(ADDR_W), .START_ADDR(START_ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .err       (err)
    );

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                ready_bad = 0;

    // Write observer: every mem_we pulse is logged, and in_ready must be low then.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            if (bus.in_ready !== 1'b0) ready_bad++;
        end
    end

    function automatic logic [31:0] basic_word(input int i);
        logic [31:0] w;
        case (i)
            0:       w = 32'h0062b233;
            1:       w = 32'h0083b233;
            default: w = 32'h00a4b233;
        endcase
        return w;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        ready_bad = 0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout in_ready=%b required=1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic load_image(input int n, input logic [31:0] words[$], input bit gaps,
                              input bit bad_csum);
        logic [7:0] x = 8'h00;
        logic [7:0] bv;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                bv = words[i][8*b +: 8];
                x  = x ^ bv;
                send_byte(bv);
                if (b == 3) begin
                    checks++;
                    if (mem_we !== 1'b1 || mem_wdata !== words[i]) begin
                        errors++;
                        $display("FAIL write_latency word=%0d we=%b data=%h required we=1 data=%h",
                                 i, mem_we, mem_wdata, words[i]);
                    end
                end
                if (gaps) @(negedge clk);
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (bad_csum) send_byte((x == 8'h00) ? 8'hff : 8'h00);
        else          send_byte(x);
`else
        if (bad_csum) x = 8'h00;
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({mem_we, core_rst, done, err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_ctrl we/crst/done/err=%b required=0100",
                     {mem_we, core_rst, done, err});
        end
        checks++;
        if (mem_addr !== ADDR_W'(START_ADDR) || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h data=%h required addr=%h data=0",
                     mem_addr, mem_wdata, ADDR_W'(START_ADDR));
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready in_ready=%b required=1", bus.in_ready);
        end
    endtask

    task automatic test_basic(input bit gaps, input string tag);
        logic [31:0] words[$];
        do_reset();
        for (int i = 0; i < 3; i++) words.push_back(basic_word(i));
        load_image(3, words, gaps, 1'b0);
        checks++;
        if (wr_addr_q.size() != 3) begin
            errors++;
            $display("FAIL %s_count writes=%0d required=3", tag, wr_addr_q.size());
        end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ADDR_W'(START_ADDR + i) || wr_data_q[i] !== words[i]) begin
                errors++;
                $display("FAIL %s_write%0d addr=%h data=%h required addr=%h data=%h", tag, i,
                         wr_addr_q[i], wr_data_q[i], ADDR_W'(START_ADDR + i), words[i]);
            end
        end
        checks++;
        if ({done, core_rst, err} !== 3'b100 || ready_bad != 0) begin
            errors++;
            $display("FAIL %s_final done/crst/err=%b ready_in_write=%0d required=100 and 0",
                     tag, {done, core_rst, err}, ready_bad);
        end
        // Bytes offered after completion must be ignored.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() != 3 || bus.in_ready !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_sticky writes=%0d ready=%b done=%b required 3/0/1", tag,
                     wr_addr_q.size(), bus.in_ready, done);
        end
    endtask

    task automatic test_empty();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        checks++;
        if ({done, core_rst, err} !== 3'b100) begin
            errors++;
            $display("FAIL empty_done done/crst/err=%b required=100", {done, core_rst, err});
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL empty_writes writes=%0d required=0", wr_addr_q.size());
        end
    endtask

    task automatic test_oversize();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        checks++;
        if ({err, core_rst, done, bus.in_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL oversize_flags err/crst/done/ready=%b required=1100",
                     {err, core_rst, done, bus.in_ready});
        end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() != 0 || err !== 1'b1 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL oversize_hold writes=%0d err=%b crst=%b required 0/1/1",
                     wr_addr_q.size(), err, core_rst);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] words[$];
        logic [31:0] w;
        do_reset();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) begin
            w = basic_word(i / 4);
            send_byte(w[8*(i%4) +: 8]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({core_rst, bus.in_ready, done, mem_we} !== 4'b1100) begin
            errors++;
            $display("FAIL midrst_state crst/ready/done/we=%b required=1100",
                     {core_rst, bus.in_ready, done, mem_we});
        end
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 3; i++) words.push_back(basic_word(i));
        load_image(3, words, 1'b0, 1'b0);
        checks++;
        if (wr_addr_q.size() != 3 || done !== 1'b1 || core_rst !== 1'b0) begin
            errors++;
            $display("FAIL midrst_reload writes=%0d done=%b crst=%b required 3/1/0",
                     wr_addr_q.size(), done, core_rst);
        end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== ADDR_W'(START_ADDR + i) || wr_data_q[i] !== words[i]) begin
                errors++;
                $display("FAIL midrst_write%0d addr=%h data=%h required addr=%h data=%h", i,
                         wr_addr_q[i], wr_data_q[i], ADDR_W'(START_ADDR + i), words[i]);
            end
        end
    endtask

    task automatic test_random(input int n, input bit gaps, input string tag);
        logic [31:0] words[$];
        int          bad = 0;
        do_reset();
        for (int i = 0; i < n; i++) words.push_back($urandom);
        load_image(n, words, gaps, 1'b0);
        checks++;
        if (wr_addr_q.size() != n || {done, core_rst, err} !== 3'b100) begin
            errors++;
            $display("FAIL %s_end writes=%0d done/crst/err=%b required %0d/100", tag,
                     wr_addr_q.size(), {done, core_rst, err}, n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== ADDR_W'(START_ADDR + i) || wr_data_q[i] !== words[i]) begin
                if (bad == 0)
                    $display("FAIL %s_write%0d addr=%h data=%h required addr=%h data=%h", tag, i,
                             wr_addr_q[i], wr_data_q[i], ADDR_W'(START_ADDR + i), words[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (wr_addr_q.size() == n && wr_addr_q[n-1] !== ADDR_W'(START_ADDR + n - 1)) begin
            errors++;
            $display("FAIL %s_last addr=%h required=%h", tag, wr_addr_q[n-1],
                     ADDR_W'(START_ADDR + n - 1));
        end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        logic [31:0] words[$];
        do_reset();
        for (int i = 0; i < 3; i++) words.push_back(basic_word(i));
        load_image(3, words, 1'b0, 1'b1);
        checks++;
        if ({err, core_rst, done} !== 3'b110 || wr_addr_q.size() != 3) begin
            errors++;
            $display("FAIL badcsum err/crst/done=%b writes=%0d required 110 and 3",
                     {err, core_rst, done}, wr_addr_q.size());
        end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "backpressure");
        test_empty();
        test_oversize();
        test_reset_mid();
        test_random(256 - START_ADDR, 1'b0, "full");
        for (int r = 0; r < 6; r++)
            test_random(int'($urandom_range(1, 12)), 1'($urandom), "random");
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
